// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver
// Brief    : Multiplexed seven-segment scanner with tear-free double-buffered
//            loads, per-digit blinking and optional active-low pin drive.
// Revision : 1.0
// ============================================================================

module seven_seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [5*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int c_presc_w = $clog2(PRESCALE);
    localparam int c_digit_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_frame_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
    localparam logic [c_digit_w-1:0] c_digit_last = c_digit_w'(DIGITS - 1);
    localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(BLINK_FRAMES - 1);
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
    localparam logic [c_digit_w-1:0] c_digit_one  = c_digit_w'(1);
    localparam logic [c_frame_w-1:0] c_frame_one  = c_frame_w'(1);

    localparam logic                c_inv        = (ACTIVE_LOW != 0);
    localparam logic [5*DIGITS-1:0] c_blank_data = {DIGITS{5'd31}};

    // Scan timing state
    logic [c_presc_w-1:0] r_presc;
    logic [c_digit_w-1:0] r_digit;
    logic [c_frame_w-1:0] r_frame;
    logic                 r_blink_phase;

    // Double-buffered display contents
    logic                 r_pending;
    logic [5*DIGITS-1:0]  r_shadow_data;
    logic [DIGITS-1:0]    r_shadow_dp;
    logic [DIGITS-1:0]    r_shadow_blink;
    logic [5*DIGITS-1:0]  r_disp_data;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [DIGITS-1:0]    r_disp_blink;

    // Output registers
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [DIGITS-1:0]    r_an;
    logic                 r_frame_tick;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic                 w_accept;
    logic [4:0]           w_codes [DIGITS];
    logic [4:0]           w_code;
    logic                 w_blank;
    logic [6:0]           w_seg_raw;
    logic [6:0]           w_seg_log;
    logic                 w_dp_log;
    logic [DIGITS-1:0]    w_an_log;

    assign w_slot_end  = (r_presc == c_presc_last);
    assign w_frame_end = w_slot_end && (r_digit == c_digit_last);
    assign w_accept    = load_valid && !r_pending;
    assign load_ready  = !r_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_digit       <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_presc <= '0;
                r_digit <= (r_digit == c_digit_last) ? '0 : r_digit + c_digit_one;
            end else begin
                r_presc <= r_presc + c_presc_one;
            end
            if (w_frame_end) begin
                if (r_frame == c_frame_last) begin
                    r_frame       <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame <= r_frame + c_frame_one;
                end
            end
        end
    end

    // Display only changes at a frame boundary, so a frame never mixes old and new digits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending      <= 1'b0;
            r_shadow_data  <= c_blank_data;
            r_shadow_dp    <= '0;
            r_shadow_blink <= '0;
            r_disp_data    <= c_blank_data;
            r_disp_dp      <= '0;
            r_disp_blink   <= '0;
        end else begin
            if (w_accept) begin
                r_shadow_data  <= data_in;
                r_shadow_dp    <= dp_in;
                r_shadow_blink <= blink_in;
            end
            if (w_frame_end && r_pending) begin
                r_disp_data  <= r_shadow_data;
                r_disp_dp    <= r_shadow_dp;
                r_disp_blink <= r_shadow_blink;
            end
            if (w_accept) begin
                r_pending <= 1'b1;
            end else if (w_frame_end) begin
                r_pending <= 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_unpack
            assign w_codes[i] = r_disp_data[5*i +: 5];
        end
    endgenerate

    assign w_code  = w_codes[r_digit];
    assign w_blank = r_blink_phase && r_disp_blink[r_digit];

    always_comb begin
        w_seg_raw = 7'h00;
        case (w_code)
            5'd0:    w_seg_raw = 7'h7E;
            5'd1:    w_seg_raw = 7'h30;
            5'd2:    w_seg_raw = 7'h6D;
            5'd3:    w_seg_raw = 7'h79;
            5'd4:    w_seg_raw = 7'h33;
            5'd5:    w_seg_raw = 7'h5B;
            5'd6:    w_seg_raw = 7'h5F;
            5'd7:    w_seg_raw = 7'h70;
            5'd8:    w_seg_raw = 7'h7F;
            5'd9:    w_seg_raw = 7'h7B;
            5'd10:   w_seg_raw = 7'h77;
            5'd11:   w_seg_raw = 7'h1F;
            5'd12:   w_seg_raw = 7'h4E;
            5'd13:   w_seg_raw = 7'h3D;
            5'd14:   w_seg_raw = 7'h4F;
            5'd15:   w_seg_raw = 7'h47;
            5'd16:   w_seg_raw = 7'h01;
            default: w_seg_raw = 7'h00;
        endcase
    end

    always_comb begin
        w_seg_log         = w_blank ? 7'h00 : w_seg_raw;
        w_dp_log          = !w_blank && r_disp_dp[r_digit];
        w_an_log          = '0;
        w_an_log[r_digit] = 1'b1;
    end

    // Pin polarity is applied only here; all upstream logic is active-high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= {7{c_inv}};
            r_dp         <= c_inv;
            r_an         <= {DIGITS{c_inv}};
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_log ^ {7{c_inv}};
            r_dp         <= w_dp_log ^ c_inv;
            r_an         <= w_an_log ^ {DIGITS{c_inv}};
            r_frame_tick <= w_frame_end;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_driver
// Brief    : Self-checking bench: frame-level reference model plus directed
//            literal expectations for the scan driver.
// Revision : 1.0
// ============================================================================

module tb_seven_seg_scan_driver;

    localparam int c_d  = 4;
    localparam int c_p  = 4;
    localparam int c_bf = 2;
    localparam int c_pd = c_p * c_d;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [19:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    seven_seg_scan_driver #(
        .DIGITS(c_d), .PRESCALE(c_p), .BLINK_FRAMES(c_bf), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .data_in(data_in), .dp_in(dp_in), .blink_in(blink_in),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          frame;
        logic [19:0] data;
        logic [3:0]  dpb;
        logic [3:0]  blk;
    } load_t;

    load_t       loads[$];
    load_t       tmp;
    int          k = 0;
    bit          active = 0;
    int          la = 0;
    bit          la_valid = 0;

    logic [6:0]  dec_tbl [17] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
                                  7'h01};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, k);
        end
    endtask

    // A load accepted at state j is pending until the end of the frame holding j+1
    function automatic bit model_ready(int j);
        return !(la_valid && la < j && (la + 1) / c_pd == j / c_pd);
    endfunction

    function automatic logic [6:0] decode(int c);
        if (c <= 16) return dec_tbl[c];
        return 7'h00;
    endfunction

    int          j, f, d, code;
    logic [19:0] cd;
    logic [3:0]  cdp, cbl;
    bit          blank;
    logic [6:0]  e_seg;
    logic        e_dp, e_ft;
    logic [3:0]  e_an;

    always @(posedge clk) begin
        if (!rst_n) begin
            k        = 0;
            la_valid = 0;
            loads.delete();
            active   = 1;
        end else if (active) begin
            if (load_valid && model_ready(k)) begin
                tmp.frame = (k + 1) / c_pd + 1;
                tmp.data  = data_in;
                tmp.dpb   = dp_in;
                tmp.blk   = blink_in;
                loads.push_back(tmp);
                la       = k;
                la_valid = 1;
            end
            k++;
        end
        #1;
        if (active) begin
            if (k == 0) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
            end else begin
                j   = k - 1;
                f   = j / c_pd;
                d   = (j / c_p) % c_d;
                cd  = 20'hFFFFF; cdp = 4'h0; cbl = 4'h0;
                for (int i = loads.size() - 1; i >= 0; i--) begin
                    if (loads[i].frame <= f) begin
                        cd = loads[i].data; cdp = loads[i].dpb; cbl = loads[i].blk;
                        break;
                    end
                end
                blank = ((f / c_bf) % 2 == 1) && cbl[d];
                code  = int'(cd[5*d +: 5]);
                e_seg = ~(blank ? 7'h00 : decode(code));
                e_dp  = ~(!blank && cdp[d]);
                e_an  = ~(4'b0001 << d);
                e_ft  = (k % c_pd == 0);
            end
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_dp", 32'(dp), 32'(e_dp));
            chk("model_an", 32'(an), 32'(e_an));
            chk("model_frame_tick", 32'(frame_tick), 32'(e_ft));
            chk("model_load_ready", 32'(load_ready), 32'(model_ready(k)));
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int hs;

    initial begin
        // Idle scan after reset
        do_reset();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_ready", 32'(load_ready), 32'h1);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        step(1);  chk("idle_an0", 32'(an), 32'hE); chk("idle_seg", 32'(seg), 32'h7F);
        step(4);  chk("idle_an1", 32'(an), 32'hD);
        step(4);  chk("idle_an2", 32'(an), 32'hB);
        step(4);  chk("idle_an3", 32'(an), 32'h7);
        step(3);  chk("idle_tick", 32'(frame_tick), 32'h1);
        step(1);  chk("idle_tick_end", 32'(frame_tick), 32'h0);

        // Mid-frame load appears on the next frame only
        do_reset();
        step(5);
        load_valid = 1'b1; data_in = {5'd3, 5'd2, 5'd1, 5'd0}; dp_in = '0; blink_in = '0;
        step(1);  load_valid = 1'b0;
        chk("load_ready_low", 32'(load_ready), 32'h0);
        step(9);  chk("load_ready_hold", 32'(load_ready), 32'h0);
        step(1);  chk("load_ready_back", 32'(load_ready), 32'h1);
        step(2);  chk("load_d0", 32'(seg), 32'h01); chk("load_an0", 32'(an), 32'hE);
        step(4);  chk("load_d1", 32'(seg), 32'h4F);
        step(4);  chk("load_d2", 32'(seg), 32'h12);
        step(4);  chk("load_d3", 32'(seg), 32'h06);

        // Blinking digit 1
        do_reset();
        load_valid = 1'b1; data_in = {4{5'd8}}; dp_in = 4'hF; blink_in = 4'b0010;
        step(1);  load_valid = 1'b0;
        step(33); chk("blink_d0", 32'(seg), 32'h00); chk("blink_dp0", 32'(dp), 32'h0);
        step(4);  chk("blink_d1_off", 32'(seg), 32'h7F); chk("blink_dp1_off", 32'(dp), 32'h1);
        step(32); chk("blink_d1_on", 32'(seg), 32'h00);

        // Dash, blanks and decimal point
        do_reset();
        load_valid = 1'b1; data_in = {5'd0, 5'd16, 5'd31, 5'd17}; dp_in = 4'b0100; blink_in = '0;
        step(1);  load_valid = 1'b0;
        step(17); chk("code17", 32'(seg), 32'h7F);
        step(4);  chk("code31", 32'(seg), 32'h7F);
        step(4);  chk("code16", 32'(seg), 32'h7E); chk("code16_dp", 32'(dp), 32'h0);
        chk("code16_an", 32'(an), 32'hB);

        // Continuous load_valid: one accept per frame
        do_reset();
        load_valid = 1'b1;
        hs = 0;
        for (int i = 0; i < 64; i++) begin
            data_in = 20'($urandom);
            if (load_valid && load_ready) hs++;
            step(1);
        end
        load_valid = 1'b0;
        chk("accepts_per_4_frames", 32'(hs), 32'd4);

        // Reset with a load pending discards everything
        do_reset();
        load_valid = 1'b1; data_in = {4{5'd8}}; dp_in = 4'hF; blink_in = '0;
        step(1);  load_valid = 1'b0;
        step(19);
        load_valid = 1'b1; data_in = {4{5'd1}};
        step(1);  load_valid = 1'b0;
        chk("pend_ready", 32'(load_ready), 32'h0);
        step(2);
        do_reset();
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_ready", 32'(load_ready), 32'h1);
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("post_rst_blank", 32'(seg), 32'h7F);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 499) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            data_in    = 20'($urandom);
            dp_in      = 4'($urandom);
            blink_in   = 4'($urandom);
            step(1);
        end
        rst_n = 1'b1;
        load_valid = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
